// File: rtl/uop_sequencer_pkg.sv
// Shared micro-op definitions for the decode-to-execute sequencer.
package uop_sequencer_pkg;

    localparam int UOP_W = 20;

    localparam logic [1:0] UC_ONE   = 2'b00;
    localparam logic [1:0] UC_TWO   = 2'b01;
    localparam logic [1:0] UC_THREE = 2'b10;

    localparam int ALU_OP_HI = 19;
    localparam int ALU_OP_LO = 16;
    localparam int DEST_HI   = 11;
    localparam int DEST_LO   = 8;
    localparam int SEL_HI    = 7;
    localparam int SEL_LO    = 6;

endpackage

// File: rtl/uop_queue_mem.sv
// Micro-op storage: three writes at consecutive slots, one async read.
module uop_queue_mem #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int W     = 21
) (
    input  logic             clk,
    input  logic             we0,
    input  logic             we1,
    input  logic             we2,
    input  logic [PTR_W-1:0] waddr,
    input  logic [W-1:0]     wd0,
    input  logic [W-1:0]     wd1,
    input  logic [W-1:0]     wd2,
    input  logic [PTR_W-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] waddr1;
    logic [PTR_W-1:0] waddr2;

    // Power-of-two depth lets the adders wrap for free.
    assign waddr1 = waddr + PTR_W'(1);
    assign waddr2 = waddr + PTR_W'(2);

    always_ff @(posedge clk) begin
        if (we0) mem[waddr]  <= wd0;
        if (we1) mem[waddr1] <= wd1;
        if (we2) mem[waddr2] <= wd2;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uop_sequencer.sv
// Buffers decoded micro-op bundles and issues them one per cycle.
module uop_sequencer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int UOP_W = uop_sequencer_pkg::UOP_W
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             flush,
    output logic             feed_req,
    input  logic             feed_ack,
    input  logic [UOP_W-1:0] uop_0,
    input  logic [UOP_W-1:0] uop_1,
    input  logic [UOP_W-1:0] uop_2,
    input  logic [1:0]       uop_count,
    output logic             uop_valid,
    input  logic             uop_ready,
    output logic [UOP_W-1:0] uop,
    output logic             uop_last,
    output logic [PTR_W:0]   level
);

    import uop_sequencer_pkg::*;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   level_q;
    logic             push;
    logic             pop;
    logic [1:0]       n;
    logic             we0;
    logic             we1;
    logic             we2;
    logic [UOP_W:0]   wd0;
    logic [UOP_W:0]   wd1;
    logic [UOP_W:0]   wd2;
    logic [UOP_W:0]   rdata;

    assign level     = level_q;
    assign uop_valid = (level_q != '0);
    assign feed_req  = a_rst & ~flush
                     & (level_q <= (PTR_W+1)'(DEPTH-3));
    assign push      = feed_ack & feed_req;
    assign pop       = uop_valid & uop_ready & ~flush;

    // Slot 0 always holds the first micro-op to issue.
    always_comb begin
        n   = 2'd3;
        wd0 = {1'b0, uop_2};
        wd1 = {1'b0, uop_1};
        wd2 = {1'b1, uop_0};
        unique case (1'b1)
            uop_count == UC_ONE: begin
                n   = 2'd1;
                wd0 = {1'b1, uop_0};
            end
            uop_count == UC_TWO: begin
                n   = 2'd2;
                wd0 = {1'b0, uop_1};
                wd1 = {1'b1, uop_0};
            end
            default: ;
        endcase
    end

    assign we0 = push;
    assign we1 = push & (n != 2'd1);
    assign we2 = push & (n == 2'd3);

    always_ff @(posedge clk) begin
        if (!a_rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            rd_ptr  <= wr_ptr;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(n);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level_q <= level_q
                     + (push ? (PTR_W+1)'(n) : '0)
                     - (PTR_W+1)'(pop);
        end
    end

    uop_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .W     (UOP_W + 1)
    ) u_mem (
        .clk   (clk),
        .we0   (we0),
        .we1   (we1),
        .we2   (we2),
        .waddr (wr_ptr),
        .wd0   (wd0),
        .wd1   (wd1),
        .wd2   (wd2),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // An empty queue presents zeros rather than stale storage.
    assign uop      = uop_valid ? rdata[UOP_W-1:0] : '0;
    assign uop_last = uop_valid & rdata[UOP_W];

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed bench with a queue-based reference model for uop_sequencer.
module tb_uop_sequencer;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int UOP_W = 20;

    logic             clk = 1'b0;
    logic             a_rst;
    logic             flush;
    logic             feed_req;
    logic             feed_ack;
    logic [UOP_W-1:0] uop_0;
    logic [UOP_W-1:0] uop_1;
    logic [UOP_W-1:0] uop_2;
    logic [1:0]       uop_count;
    logic             uop_valid;
    logic             uop_ready;
    logic [UOP_W-1:0] uop;
    logic             uop_last;
    logic [PTR_W:0]   level;

    int nvec = 0;
    int nerr = 0;

    logic [UOP_W:0] mq [$];

    uop_sequencer #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .UOP_W (UOP_W)
    ) dut (
        .clk       (clk),
        .a_rst     (a_rst),
        .flush     (flush),
        .feed_req  (feed_req),
        .feed_ack  (feed_ack),
        .uop_0     (uop_0),
        .uop_1     (uop_1),
        .uop_2     (uop_2),
        .uop_count (uop_count),
        .uop_valid (uop_valid),
        .uop_ready (uop_ready),
        .uop       (uop),
        .uop_last  (uop_last),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of {last, uop}; the spec's rules applied to it.
    always @(posedge clk) begin
        bit mreq;
        bit mpop;
        int n;
        mreq = a_rst && !flush && (mq.size() <= DEPTH - 3);
        mpop = a_rst && !flush && (mq.size() != 0) && uop_ready;
        if (!a_rst || flush) begin
            mq.delete();
        end else begin
            if (mpop) void'(mq.pop_front());
            if (feed_ack && mreq) begin
                n = (uop_count == 2'd0) ? 1 : (uop_count == 2'd1) ? 2 : 3;
                if (n == 3) mq.push_back({1'b0, uop_2});
                if (n >= 2) mq.push_back({1'b0, uop_1});
                mq.push_back({1'b1, uop_0});
            end
        end
    end

    always @(negedge clk) begin
        logic [UOP_W:0] hd;
        hd = (mq.size() != 0) ? mq[0] : '0;
        chk("m_valid", 32'(uop_valid), 32'(mq.size() != 0));
        chk("m_uop", 32'(uop), 32'(hd[UOP_W-1:0]));
        chk("m_last", 32'(uop_last), 32'(hd[UOP_W]));
        chk("m_level", 32'(level), 32'(mq.size()));
        chk("m_feed_req", 32'(feed_req),
            32'(a_rst && !flush && (mq.size() <= DEPTH - 3)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst     = 1'b0;
        flush     = 1'b0;
        feed_ack  = 1'b1;
        uop_count = 2'b10;
        uop_0     = 20'h12345;
        uop_1     = 20'h23456;
        uop_2     = 20'h34567;
        uop_ready = 1'b0;

        // Reset with a bundle offered
        tick();
        tick();
        chk("rst_valid", 32'(uop_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_uop", 32'(uop), 32'd0);
        chk("rst_feed_req", 32'(feed_req), 32'd0);
        a_rst    = 1'b1;
        feed_ack = 1'b0;
        #1;
        chk("rel_feed_req", 32'(feed_req), 32'd1);

        // Three-uop bundle
        feed_ack  = 1'b1;
        uop_count = 2'b10;
        uop_2     = 20'h0_0A01;
        uop_1     = 20'h7_0502;
        uop_0     = 20'h0_0303;
        uop_ready = 1'b1;
        tick();
        feed_ack = 1'b0;
        chk("b3_uop0", 32'(uop), 32'h0A01);
        chk("b3_last0", 32'(uop_last), 32'd0);
        tick();
        chk("b3_uop1", 32'(uop), 32'h70502);
        chk("b3_last1", 32'(uop_last), 32'd0);
        tick();
        chk("b3_uop2", 32'(uop), 32'h0303);
        chk("b3_last2", 32'(uop_last), 32'd1);
        tick();
        chk("b3_empty", 32'(uop_valid), 32'd0);

        // Back-pressure fill to the threshold
        uop_ready = 1'b0;
        feed_ack  = 1'b1;
        uop_count = 2'b00;
        for (int i = 0; i < 6; i++) begin
            uop_0 = 20'h01000 + 20'(i);
            tick();
            chk("bp_level", 32'(level), 32'(i + 1));
        end
        chk("bp_feed_req", 32'(feed_req), 32'd0);
        uop_0 = 20'hDEAD0;
        tick();
        tick();
        chk("bp_ignored", 32'(level), 32'd6);
        feed_ack  = 1'b0;
        uop_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("bp_order", 32'(uop), 32'h1000 + 32'(i));
            chk("bp_last", 32'(uop_last), 32'd1);
            tick();
        end
        chk("bp_drained", 32'(uop_valid), 32'd0);

        // Move pointers from 1 to 6; count 11 behaves as three
        feed_ack  = 1'b1;
        uop_count = 2'b11;
        uop_2     = 20'h30001;
        uop_1     = 20'h30002;
        uop_0     = 20'h30003;
        tick();
        feed_ack = 1'b0;
        chk("uc11_level", 32'(level), 32'd3);
        tick();
        tick();
        tick();
        feed_ack  = 1'b1;
        uop_count = 2'b01;
        uop_1     = 20'h40001;
        uop_0     = 20'h40002;
        tick();
        feed_ack = 1'b0;
        chk("b2_uop0", 32'(uop), 32'h40001);
        tick();
        chk("b2_uop1", 32'(uop), 32'h40002);
        tick();
        chk("adv_level", 32'(level), 32'd0);

        // Bundle straddling the wrap: slots 6, 7, 0
        feed_ack  = 1'b1;
        uop_count = 2'b10;
        uop_2     = 20'hAAAA1;
        uop_1     = 20'hBBBB2;
        uop_0     = 20'hCCCC3;
        tick();
        feed_ack = 1'b0;
        chk("wr_uop0", 32'(uop), 32'hAAAA1);
        chk("wr_last0", 32'(uop_last), 32'd0);
        tick();
        chk("wr_uop1", 32'(uop), 32'hBBBB2);
        chk("wr_last1", 32'(uop_last), 32'd0);
        tick();
        chk("wr_uop2", 32'(uop), 32'hCCCC3);
        chk("wr_last2", 32'(uop_last), 32'd1);
        tick();
        chk("wr_empty", 32'(uop_valid), 32'd0);

        // Simultaneous push and pop at level 2
        uop_ready = 1'b0;
        feed_ack  = 1'b1;
        uop_count = 2'b01;
        uop_1     = 20'h11111;
        uop_0     = 20'h22222;
        tick();
        chk("sim_level2", 32'(level), 32'd2);
        uop_ready = 1'b1;
        uop_1     = 20'h33333;
        uop_0     = 20'h44444;
        tick();
        feed_ack = 1'b0;
        chk("sim_level3", 32'(level), 32'd3);
        chk("sim_head", 32'(uop), 32'h22222);
        tick();
        tick();
        tick();
        chk("sim_empty", 32'(uop_valid), 32'd0);

        // Flush with a concurrent ack at level 5
        uop_ready = 1'b0;
        feed_ack  = 1'b1;
        uop_count = 2'b10;
        uop_2     = 20'h50001;
        uop_1     = 20'h50002;
        uop_0     = 20'h50003;
        tick();
        uop_count = 2'b01;
        uop_1     = 20'h60001;
        uop_0     = 20'h60002;
        tick();
        chk("fl_level5", 32'(level), 32'd5);
        flush     = 1'b1;
        uop_count = 2'b10;
        uop_2     = 20'hEEEE1;
        uop_1     = 20'hEEEE2;
        uop_0     = 20'hEEEE3;
        #1;
        chk("fl_feed_req", 32'(feed_req), 32'd0);
        tick();
        flush    = 1'b0;
        feed_ack = 1'b0;
        chk("fl_level0", 32'(level), 32'd0);
        chk("fl_valid", 32'(uop_valid), 32'd0);
        feed_ack  = 1'b1;
        uop_count = 2'b00;
        uop_0     = 20'h77777;
        tick();
        feed_ack = 1'b0;
        chk("fl_after_uop", 32'(uop), 32'h77777);
        chk("fl_after_lvl", 32'(level), 32'd1);
        uop_ready = 1'b1;
        tick();
        chk("fl_after_empty", 32'(uop_valid), 32'd0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
